// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Size encodings match the main decoder's byte_en field.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_DONE  = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    function automatic logic be_legal(input logic [3:0] be);
        return (be == BE_BYTE) || (be == BE_HALF) ||
               (be == BE_WORD) || (be == BE_NONE);
    endfunction

    // Byte lanes touched across two consecutive words
    function automatic logic [7:0] lane_mask(
        input logic [3:0] be,
        input logic [1:0] off
    );
        return {4'b0000, be} << off;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data alignment: shifts the beat pair down to the access
// offset, then masks to size and sign- or zero-extends.
module load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] beats,
    input  logic [1:0]          off,
    input  logic [3:0]          byte_en,
    input  logic                sign_ext,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] w;

    always_comb begin
        w     = DATA_W'(beats >> {off, 3'b000});
        rdata = '0;
        unique case (1'b1)
            byte_en == BE_BYTE:
                rdata = {{(DATA_W-8){sign_ext & w[7]}}, w[7:0]};
            byte_en == BE_HALF:
                rdata = {{(DATA_W-16){sign_ext & w[15]}}, w[15:0]};
            byte_en == BE_WORD:
                rdata = w;
            default:
                rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time over a word-wide req/ack bus.
// Define LSU_MISALIGNED_SPLIT_EN to run misaligned accesses as two beats.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              ready_o,
    input  logic              mem_wr_en_i,
    input  logic [3:0]        byte_en_i,
    input  logic              signed_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misaligned_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    lsu_state_e state_q, state_d;

    logic                wr_q;
    logic                sgn_q;
    logic                mis_q;
    logic [3:0]          be_q;
    logic [1:0]          off_q;
    logic [7:0]          mask_q;
    logic [ADDR_W-3:0]   word_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [2*DATA_W-1:0] rbuf_q;

    logic [3:0]          be_n;
    logic [7:0]          mask_n;
    logic                mis_n;
    logic                reject;
    logic [2*DATA_W-1:0] wsh;
    logic [DATA_W-1:0]   ld_data;

    assign be_n   = be_legal(byte_en_i) ? byte_en_i : BE_NONE;
    assign mask_n = lane_mask(be_n, addr_i[1:0]);
    assign mis_n  = |mask_n[7:4];
    assign wsh    = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign reject = 1'b0;
`else
    assign reject = mis_q;
`endif

    load_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .beats   (rbuf_q),
        .off     (off_q),
        .byte_en (be_q),
        .sign_ext(sgn_q),
        .rdata   (ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            mis_q   <= 1'b0;
            be_q    <= BE_NONE;
            off_q   <= '0;
            mask_q  <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else begin
            if (state_q == S_IDLE && req_valid_i) begin
                wr_q    <= mem_wr_en_i;
                sgn_q   <= signed_i;
                mis_q   <= mis_n;
                be_q    <= be_n;
                off_q   <= addr_i[1:0];
                mask_q  <= mask_n;
                word_q  <= addr_i[ADDR_W-1:2];
                wdata_q <= wdata_i;
                rbuf_q  <= '0;
            end
            if (state_q == S_BEAT0 && bus_ack_i) begin
                rbuf_q[DATA_W-1:0] <= bus_rdata_i;
            end
            if (state_q == S_BEAT1 && bus_ack_i) begin
                rbuf_q[2*DATA_W-1:DATA_W] <= bus_rdata_i;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ready_o      = 1'b0;
        done_o       = 1'b0;
        rdata_o      = '0;
        misaligned_o = 1'b0;
        bus_req_o    = 1'b0;
        bus_we_o     = 1'b0;
        bus_addr_o   = '0;
        bus_be_o     = '0;
        bus_wdata_o  = '0;

        unique case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (req_valid_i) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (mask_n[3:0] == 4'b0000) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BEAT0;
                    end
`else
                    if (mask_n[3:0] == 4'b0000 || mis_n) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BEAT0;
                    end
`endif
                end
            end
            S_BEAT0: begin
                bus_req_o   = 1'b1;
                bus_we_o    = wr_q;
                bus_addr_o  = {word_q, 2'b00};
                bus_be_o    = mask_q[3:0];
                bus_wdata_o = wsh[DATA_W-1:0];
                if (bus_ack_i) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    state_d = mis_q ? S_BEAT1 : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_BEAT1: begin
                // Word address wraps at the top of the address space
                bus_req_o   = 1'b1;
                bus_we_o    = wr_q;
                bus_addr_o  = {word_q + 1'b1, 2'b00};
                bus_be_o    = mask_q[7:4];
                bus_wdata_o = wsh[2*DATA_W-1:DATA_W];
                if (bus_ack_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o       = 1'b1;
                misaligned_o = reject;
                if (!wr_q && !reject) begin
                    rdata_o = ld_data;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a hand-driven bus.
// Misaligned expectations follow LSU_MISALIGNED_SPLIT_EN.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        ready_o;
    logic        mem_wr_en_i = 1'b0;
    logic [3:0]  byte_en_i = 4'b0;
    logic        signed_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misaligned_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;

    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    load_store_unit #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .ready_o     (ready_o),
        .mem_wr_en_i (mem_wr_en_i),
        .byte_en_i   (byte_en_i),
        .signed_i    (signed_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .misaligned_o(misaligned_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request for one edge; returns in the first beat cycle
    task automatic issue(input logic wr, input logic [3:0] be,
                         input logic sgn, input logic [31:0] a,
                         input logic [31:0] d);
        mem_wr_en_i = wr;
        byte_en_i   = be;
        signed_i    = sgn;
        addr_i      = a;
        wdata_i     = d;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        bus_ack_i   = 1'b1;
        bus_rdata_i = d;
        tick();
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_ready", ready_o, 1);
        chk("rst_req", bus_req_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        chk("rst_wdata", bus_wdata_o, 0);
        chk("rst_be", bus_be_o, 0);
        chk("rst_we", bus_we_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_mis", misaligned_o, 0);
        rst_i = 1'b0;
        tick();

        // load byte 0x103 signed, zero wait
        issue(1'b0, 4'b0001, 1'b1, 32'h0000_0103, 32'h0);
        chk("lb_req", bus_req_o, 1);
        chk("lb_ready", ready_o, 0);
        chk("lb_addr", bus_addr_o, 32'h0000_0100);
        chk("lb_be", bus_be_o, 4'b1000);
        chk("lb_we", bus_we_o, 0);
        ack(32'h80AA_BBCC);
        chk("lb_done", done_o, 1);
        chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
        chk("lb_mis", misaligned_o, 0);
        chk("lb_req_off", bus_req_o, 0);
        tick();
        chk("lb_ready_after", ready_o, 1);
        chk("lb_done_off", done_o, 0);

        // load half 0x102 unsigned, two wait cycles
        issue(1'b0, 4'b0011, 1'b0, 32'h0000_0102, 32'h0);
        chk("lh_be", bus_be_o, 4'b1100);
        tick();
        chk("lh_wait1_req", bus_req_o, 1);
        chk("lh_wait1_addr", bus_addr_o, 32'h0000_0100);
        chk("lh_wait1_done", done_o, 0);
        tick();
        chk("lh_wait2_be", bus_be_o, 4'b1100);
        ack(32'hBEEF_0000);
        chk("lh_done", done_o, 1);
        chk("lh_rdata", rdata_o, 32'h0000_BEEF);
        tick();

        // aligned store word
        issue(1'b1, 4'b1111, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF);
        chk("sw_we", bus_we_o, 1);
        chk("sw_be", bus_be_o, 4'b1111);
        chk("sw_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        ack(32'h1234_5678);
        chk("sw_done", done_o, 1);
        chk("sw_rdata", rdata_o, 0);
        tick();

        // store byte into lane 2
        issue(1'b1, 4'b0001, 1'b0, 32'h0000_0302, 32'h0000_005A);
        chk("sb_addr", bus_addr_o, 32'h0000_0300);
        chk("sb_be", bus_be_o, 4'b0100);
        chk("sb_wdata", bus_wdata_o, 32'h005A_0000);
        ack(32'h0);
        chk("sb_done", done_o, 1);
        tick();

        // no-op and illegal size: done next cycle, no bus
        issue(1'b0, 4'b0000, 1'b0, 32'h0000_0040, 32'h0);
        chk("nop_done", done_o, 1);
        chk("nop_req", bus_req_o, 0);
        chk("nop_rdata", rdata_o, 0);
        tick();
        issue(1'b0, 4'b0101, 1'b0, 32'h0000_0040, 32'h0);
        chk("ill_done", done_o, 1);
        chk("ill_req", bus_req_o, 0);
        chk("ill_mis", misaligned_o, 0);
        tick();

        // stray ack while idle is ignored
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        chk("idle_ack_ready", ready_o, 1);
        chk("idle_ack_done", done_o, 0);

        // signed byte positive, signed half negative
        issue(1'b0, 4'b0001, 1'b1, 32'h0000_0100, 32'h0);
        ack(32'h1234_567F);
        chk("lb_pos", rdata_o, 32'h0000_007F);
        tick();
        issue(1'b0, 4'b0011, 1'b1, 32'h0000_0100, 32'h0);
        ack(32'h0000_8001);
        chk("lh_neg", rdata_o, 32'hFFFF_8001);
        tick();

`ifdef LSU_MISALIGNED_SPLIT_EN
        // store word 0x201 split over two beats
        issue(1'b1, 4'b1111, 1'b0, 32'h0000_0201, 32'h1122_3344);
        chk("ms_b0_addr", bus_addr_o, 32'h0000_0200);
        chk("ms_b0_be", bus_be_o, 4'b1110);
        chk("ms_b0_wdata", bus_wdata_o, 32'h2233_4400);
        ack(32'h0);
        chk("ms_b1_req", bus_req_o, 1);
        chk("ms_b1_addr", bus_addr_o, 32'h0000_0204);
        chk("ms_b1_be", bus_be_o, 4'b0001);
        chk("ms_b1_wdata", bus_wdata_o, 32'h0000_0011);
        chk("ms_b1_we", bus_we_o, 1);
        ack(32'h0);
        chk("ms_done", done_o, 1);
        chk("ms_mis", misaligned_o, 0);
        chk("ms_rdata", rdata_o, 0);
        tick();

        // load word wrapping past the top of memory
        issue(1'b0, 4'b1111, 1'b0, 32'hFFFF_FFFE, 32'h0);
        chk("wr_b0_addr", bus_addr_o, 32'hFFFF_FFFC);
        chk("wr_b0_be", bus_be_o, 4'b1100);
        ack(32'hAAAA_0000);
        chk("wr_b1_addr", bus_addr_o, 32'h0000_0000);
        chk("wr_b1_be", bus_be_o, 4'b0011);
        ack(32'h0000_BBBB);
        chk("wr_done", done_o, 1);
        chk("wr_rdata", rdata_o, 32'hBBBB_AAAA);
        tick();
`else
        // misaligned half rejected without bus activity
        issue(1'b0, 4'b0011, 1'b0, 32'h0000_0003, 32'h0);
        chk("mr_req", bus_req_o, 0);
        chk("mr_done", done_o, 1);
        chk("mr_mis", misaligned_o, 1);
        chk("mr_rdata", rdata_o, 0);
        tick();
        chk("mr_mis_off", misaligned_o, 0);
        issue(1'b1, 4'b1111, 1'b0, 32'h0000_0201, 32'h1122_3344);
        chk("mw_req", bus_req_o, 0);
        chk("mw_mis", misaligned_o, 1);
        tick();
`endif

        // reset while waiting in the first beat
        issue(1'b0, 4'b1111, 1'b0, 32'h0000_0400, 32'h0);
        chk("ra_req", bus_req_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("ra_req_off", bus_req_o, 0);
        chk("ra_ready", ready_o, 1);
        chk("ra_done", done_o, 0);
        tick();
        chk("ra_done2", done_o, 0);
        issue(1'b0, 4'b1111, 1'b0, 32'h0000_0404, 32'h0);
        chk("ra_new_addr", bus_addr_o, 32'h0000_0404);
        ack(32'hCAFE_F00D);
        chk("ra_new_done", done_o, 1);
        chk("ra_new_rdata", rdata_o, 32'hCAFE_F00D);
        tick();
        chk("ra_new_ready", ready_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
